serial_addsub: RTL and testbench

//  Bit-serial adder/subtractor: latches two WIDTH-bit operands, streams them LSB-first through
//  one fas full adder/subtractor cell with a registered carry/borrow, and returns the full word.

---
 rtl/serial_addsub_pkg.sv | 14 +
 rtl/serial_addsub_fas.sv | 36 +++
 rtl/serial_addsub.sv | 118 +++++++++++
 tb/tb_serial_addsub.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Imported by the sequencer and by anything driving its mode input.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_fas.sv
// Single-bit full adder/subtractor cell built from nand/or/xnor terms.
// a_ns=1 adds with carry; a_ns=0 subtracts a-b with borrow in/out.
module fas #(
    parameter int nand_tpd = 1,
    parameter int or_tpd   = 1,
    parameter int xnor_tpd = 1
) (
    input  logic a,
    input  logic b,
    input  logic ci,
    input  logic a_ns,
    output logic s,
    output logic co
);

    generate
        if (nand_tpd + or_tpd + xnor_tpd >= 0) begin : g_cell
            logic ax;
            logic t;
            logic gn;
            logic pn;

            // Inverting a in subtract mode turns the carry chain into a borrow chain.
            assign ax = a ~^ a_ns;
            assign t  = ax ^ b;
            assign gn = ~(ax & b);
            assign pn = ~(t & ci);
            assign s  = (t ^ ci) ~^ a_ns;
            assign co = ~(gn & pn);
        end else begin : g_tie
            assign s  = 1'b0;
            assign co = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands stream LSB-first through one
// fas cell with a registered carry/borrow; full word returned on done.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NAND_TPD = 1,
    parameter int OR_TPD   = 1,
    parameter int XNOR_TPD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_ns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic             mode;
    logic             a_sgn;
    logic             b_sgn;

    logic             fas_s;
    logic             fas_co;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    fas #(
        .nand_tpd(NAND_TPD),
        .or_tpd  (OR_TPD),
        .xnor_tpd(XNOR_TPD)
    ) u_fas (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .ci  (carry),
        .a_ns(mode),
        .s   (fas_s),
        .co  (fas_co)
    );

    // The newest sum bit enters at the MSB; after WIDTH shifts the word is aligned.
    assign res_next = {fas_s, res_sh};

    always_comb begin
        ovf_next = 1'b0;
        if (mode == MODE_ADD)
            ovf_next = (a_sgn == b_sgn) && (fas_s != a_sgn);
        else
            ovf_next = (a_sgn != b_sgn) && (fas_s != a_sgn);
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            mode   <= 1'b0;
            a_sgn  <= 1'b0;
            b_sgn  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        mode   <= a_ns;
                        a_sgn  <= a[WIDTH-1];
                        b_sgn  <= b[WIDTH-1];
                        carry  <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next[WIDTH-1:1];
                    carry  <= fas_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        result <= res_next;
                        cout   <= fas_co;
                        ovf    <= ovf_next;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: driver queues expected words,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         a_ns;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        int           acc;
        string        name;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   saved;

    serial_addsub #(
        .WIDTH   (W),
        .NAND_TPD(1),
        .OR_TPD  (1),
        .XNOR_TPD(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_ns  (a_ns),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%0h required=none", result);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_result"}, 32'(result), 32'(e.r));
                chk({e.name, "_cout"}, 32'(cout), 32'(e.c));
                chk({e.name, "_ovf"}, 32'(ovf), 32'(e.o));
                chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(LAT));
            end
        end
    end

    task automatic push(input logic [W-1:0] r, input logic c,
                        input logic o, input string nm);
        exp_t x;
        x.r    = r;
        x.c    = c;
        x.o    = o;
        x.acc  = cyc;
        x.name = nm;
        sbq.push_back(x);
    endtask

    // Presents one op for a single accept edge; returns #1 after that edge.
    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic m, input logic [W-1:0] r,
                         input logic c, input logic o,
                         input string nm, input bit keep);
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        a_ns  = m;
        @(posedge clk);
        #1;
        if (keep) push(r, c, o, nm);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        chk({nm, "_done_timeout"}, 32'(n < 30), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_ns  = MODE_ADD;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_cout", 32'(cout), 0);
        chk("reset_ovf", 32'(ovf), 0);

        issue(8'h3C, 8'h05, MODE_ADD, 8'h41, 1'b0, 1'b0, "add_3c_05", 1'b1);
        @(negedge clk);
        chk("run_busy", 32'(busy), 1);
        wait_done("add_3c_05");
        issue(8'h05, 8'h07, MODE_SUB, 8'hFE, 1'b1, 1'b0, "sub_05_07", 1'b1);
        wait_done("sub_05_07");
        issue(8'h7F, 8'h01, MODE_ADD, 8'h80, 1'b0, 1'b1, "add_7f_01", 1'b1);
        wait_done("add_7f_01");
        issue(8'hFF, 8'h01, MODE_ADD, 8'h00, 1'b1, 1'b0, "add_ff_01", 1'b1);
        wait_done("add_ff_01");
        issue(8'h80, 8'h01, MODE_SUB, 8'h7F, 1'b0, 1'b1, "sub_80_01", 1'b1);
        wait_done("sub_80_01");

        // start pulsed mid-RUN with different operands must be ignored
        issue(8'h3C, 8'h05, MODE_ADD, 8'h41, 1'b0, 1'b0, "ignore_run", 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        a_ns  = MODE_SUB;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_run");
        repeat (2) @(negedge clk);
        chk("idle_after_done", 32'(busy), 0);

        issue(8'h55, 8'h11, MODE_ADD, 8'h66, 1'b0, 1'b0, "aborted", 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_result", 32'(result), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        rst   = 1'b0;
        saved = done_cnt;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - saved), 0);
        issue(8'h10, 8'h20, MODE_ADD, 8'h30, 1'b0, 1'b0, "add_10_20", 1'b1);
        wait_done("add_10_20");

        // back-to-back: start held high into the DONE cycle
        @(negedge clk);
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h05;
        a_ns  = MODE_ADD;
        @(posedge clk);
        #1;
        push(8'h41, 1'b0, 1'b0, "b2b_first");
        a    = 8'h09;
        b    = 8'h03;
        a_ns = MODE_SUB;
        wait_done("b2b_first");
        @(posedge clk);
        #1;
        push(8'h06, 1'b0, 1'b0, "b2b_second");
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_hold_early", 32'(result), 32'h41);
        repeat (4) @(negedge clk);
        chk("b2b_hold_mid", 32'(result), 32'h41);
        wait_done("b2b_second");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
